ooo_issue_queue: RTL and testbench

Execute-side receiver for the decode→execute handoff of the out-of-order core. Accepts decoded instruction packets from decode with a valid/ready handshake and buffers them in a DEPTH-entry in-order FIFO. Issues the head entry to its scalar functional unit once that unit is ready and a register scoreboard reports no pending writes to its sources. Supports a single-cycle flush on redirect.

---
 rtl/ooo_issue_queue_pkg.sv | 29 ++
 rtl/ooo_issue_queue_scoreboard.sv | 36 +++
 rtl/ooo_issue_queue.sv | 92 +++++++++
 tb/tb_ooo_issue_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_issue_queue_pkg.sv
// Types shared by decode, the issue queue and the scalar functional units.
package ooo_issue_queue_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_IDX_W     = 5;
    localparam int SFU_COUNT     = 4;

    // The encoding of each value is also its bit index in fu_ready.
    typedef enum logic [1:0] {
        SFU_ALU = 2'd0,
        SFU_MUL = 2'd1,
        SFU_DIV = 2'd2,
        SFU_BR  = 2'd3
    } scalar_fu_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [REG_IDX_W-1:0] reg_rs1;
        logic [REG_IDX_W-1:0] reg_rs2;
        logic [REG_IDX_W-1:0] reg_rd;
        logic                 wen;
        scalar_fu_t           sfu_type;
        logic [31:0]          rs1_data;
        logic [31:0]          rs2_data;
        logic                 halt_instr;
    } issue_entry_t;

endpackage

// File: rtl/ooo_issue_queue_scoreboard.sv
// Register busy vector: one bit per architectural register with a pending write.
module ooo_scoreboard
    import ooo_issue_queue_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_rd_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_rd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o
);

    logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;

    // Clear first so a same-cycle set of the same register wins; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_rd_i] = 1'b0;
        if (set_i) busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge CLK) begin
        if (RST) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];

endmodule

// File: rtl/ooo_issue_queue.sv
// In-order issue queue between decode and the scalar functional units.
module ooo_issue_queue
    import ooo_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NUM_FU = SFU_COUNT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         dec_valid,
    input  issue_entry_t                 dec_entry,
    output logic                         dec_ready,
    output logic                         iss_valid,
    output issue_entry_t                 iss_entry,
    input  logic [NUM_FU-1:0]            fu_ready,
    input  logic                         wb_valid,
    input  logic [REG_IDX_W-1:0]         wb_rd,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    issue_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    issue_entry_t   head;
    logic           rs1_busy, rs2_busy;
    logic           enq_fire, iss_fire, sb_set;

    assign head      = mem_q[head_q];
    assign count     = count_q;
    assign dec_ready = (count_q != CW'(DEPTH)) && !flush;
    assign iss_valid = (count_q != '0) && !rs1_busy && !rs2_busy && !flush;
    assign iss_entry = head;
    assign enq_fire  = dec_valid && dec_ready;
    assign iss_fire  = iss_valid && fu_ready[head.sfu_type];
    assign sb_set    = iss_fire && head.wen && (head.reg_rd != '0);

    ooo_scoreboard u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .set_i      (sb_set),
        .set_rd_i   (head.reg_rd),
        .clr_i      (wb_valid),
        .clr_rd_i   (wb_rd),
        .rs1_i      (head.reg_rs1),
        .rs2_i      (head.reg_rs2),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy)
    );

    // Pointer and occupancy next state; flush empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PW'(1);
            if (iss_fire) head_d = head_q + PW'(1);
            case ({enq_fire, iss_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge CLK) begin
        if (enq_fire) mem_q[tail_q] <= dec_entry;
    end

endmodule

// File: tb/tb_ooo_issue_queue.sv
// Directed bench for ooo_issue_queue with a queue-based issue-order scoreboard.
module tb_ooo_issue_queue;
    import ooo_issue_queue_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         dec_valid = 1'b0;
    issue_entry_t dec_entry = '0;
    logic         dec_ready;
    logic         iss_valid;
    issue_entry_t iss_entry;
    logic [3:0]   fu_ready = 4'hF;
    logic         wb_valid = 1'b0;
    logic [4:0]   wb_rd = '0;
    logic         flush = 1'b0;
    logic [2:0]   count;

    int tests = 0;
    int fails = 0;
    issue_entry_t exp_q [$];

    ooo_issue_queue #(.DEPTH(4), .NUM_FU(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .dec_valid (dec_valid),
        .dec_entry (dec_entry),
        .dec_ready (dec_ready),
        .iss_valid (iss_valid),
        .iss_entry (iss_entry),
        .fu_ready  (fu_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    function automatic issue_entry_t mk(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                        logic [4:0] rd, logic wen, scalar_fu_t fu);
        issue_entry_t e;
        e          = '0;
        e.pc       = pc;
        e.instr    = pc ^ 32'h0000_0013;
        e.reg_rs1  = rs1;
        e.reg_rs2  = rs2;
        e.reg_rd   = rd;
        e.wen      = wen;
        e.sfu_type = fu;
        e.rs1_data = pc + 32'd1;
        e.rs2_data = pc + 32'd2;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(issue_entry_t e);
        dec_valid = 1'b1;
        dec_entry = e;
        exp_q.push_back(e);
    endtask

    // Monitor: every issue handshake must match the oldest expected packet.
    always @(negedge CLK) begin
        if (!RST && iss_valid && fu_ready[iss_entry.sfu_type]) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: got pc %0h expected no issue", iss_entry.pc);
            end else begin
                if (iss_entry !== exp_q[0]) begin
                    fails++;
                    $display("FAIL issue_order: got pc %0h rd %0d expected pc %0h rd %0d",
                             iss_entry.pc, iss_entry.reg_rd, exp_q[0].pc, exp_q[0].reg_rd);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) cyc();
        RST = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_dec_ready", 32'(dec_ready), 1);
        chk("rst_iss_valid", 32'(iss_valid), 0);

        // Four independent ADDs streaming at full rate
        for (int k = 0; k < 6; k++) begin
            if (k < 4) send(mk(32'h100 + 32'(k), 5'd0, 5'd0, 5'(k + 1), 1'b1, SFU_ALU));
            else       dec_valid = 1'b0;
            #1;
            chk("stream_dec_ready", 32'(dec_ready), 1);
            chk("stream_iss_valid", 32'(iss_valid), (k >= 1 && k <= 4) ? 1 : 0);
            chk("stream_count", 32'(count), (k >= 1 && k <= 4) ? 1 : 0);
            cyc();
        end

        // Fill with FUs stalled, then release
        fu_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            send(mk(32'h200 + 32'(i), 5'd0, 5'd0, 5'(8 + i), 1'b0, SFU_MUL));
            cyc();
        end
        send(mk(32'h204, 5'd0, 5'd0, 5'd12, 1'b0, SFU_MUL));
        #1;
        chk("full_count", 32'(count), 4);
        chk("full_dec_ready", 32'(dec_ready), 0);
        chk("full_iss_valid", 32'(iss_valid), 1);
        cyc();
        #1;
        chk("full_hold_count", 32'(count), 4);
        cyc();
        fu_ready = 4'hF;
        #1;
        chk("full_release_dec_ready", 32'(dec_ready), 0);
        cyc();
        #1;
        chk("after_release_count", 32'(count), 3);
        chk("after_release_dec_ready", 32'(dec_ready), 1);
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("overlap_count", 32'(count), 3);
        repeat (3) cyc();
        chk("drain_count", 32'(count), 0);

        // RAW hazard: MUL x5 then ADD reading x5
        send(mk(32'h300, 5'd0, 5'd0, 5'd5, 1'b1, SFU_MUL));
        cyc();
        send(mk(32'h301, 5'd5, 5'd0, 5'd6, 1'b1, SFU_ALU));
        #1;
        chk("raw_producer_valid", 32'(iss_valid), 1);
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("raw_hold_valid", 32'(iss_valid), 0);
        chk("raw_hold_count", 32'(count), 1);
        cyc();
        #1;
        chk("raw_hold2_valid", 32'(iss_valid), 0);
        cyc();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        chk("raw_no_bypass", 32'(iss_valid), 0);
        cyc();
        wb_valid = 1'b0;
        #1;
        chk("raw_after_wb_valid", 32'(iss_valid), 1);
        cyc();
        chk("raw_done_count", 32'(count), 0);

        // Set beats clear on x7
        send(mk(32'h400, 5'd0, 5'd0, 5'd7, 1'b1, SFU_ALU));
        cyc();
        send(mk(32'h401, 5'd0, 5'd7, 5'd0, 1'b0, SFU_ALU));
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        chk("setclr_writer_valid", 32'(iss_valid), 1);
        cyc();
        dec_valid = 1'b0;
        wb_valid  = 1'b0;
        #1;
        chk("setclr_busy_kept", 32'(iss_valid), 0);
        cyc();
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        chk("setclr_wait", 32'(iss_valid), 0);
        cyc();
        wb_valid = 1'b0;
        #1;
        chk("setclr_release", 32'(iss_valid), 1);
        cyc();
        chk("setclr_count", 32'(count), 0);

        // Flush with three queued and an incoming packet
        fu_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            send(mk(32'h500 + 32'(i), 5'd0, 5'd0, 5'd0, 1'b0, SFU_DIV));
            cyc();
        end
        dec_entry = mk(32'h5FF, 5'd0, 5'd0, 5'd0, 1'b0, SFU_ALU);
        flush     = 1'b1;
        fu_ready  = 4'hF;
        #1;
        chk("flush_count_before", 32'(count), 3);
        chk("flush_dec_ready", 32'(dec_ready), 0);
        chk("flush_iss_valid", 32'(iss_valid), 0);
        cyc();
        flush     = 1'b0;
        dec_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_count_after", 32'(count), 0);
        chk("flush_iss_after", 32'(iss_valid), 0);
        send(mk(32'h510, 5'd6, 5'd0, 5'd0, 1'b0, SFU_ALU));
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("flush_reader_count", 32'(count), 1);
        chk("flush_busy_retained", 32'(iss_valid), 0);
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        cyc();
        wb_valid = 1'b0;
        #1;
        chk("flush_reader_release", 32'(iss_valid), 1);
        cyc();
        chk("flush_done_count", 32'(count), 0);

        // rd = 0 write never marks x0 busy
        send(mk(32'h600, 5'd0, 5'd0, 5'd0, 1'b1, SFU_ALU));
        cyc();
        send(mk(32'h601, 5'd0, 5'd0, 5'd0, 1'b0, SFU_ALU));
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("x0_reader_valid", 32'(iss_valid), 1);
        cyc();
        chk("x0_done_count", 32'(count), 0);

        // Reset mid-operation clears queue and scoreboard (x1, x2 busy from stream)
        fu_ready = 4'h0;
        send(mk(32'h700, 5'd0, 5'd0, 5'd0, 1'b0, SFU_ALU));
        cyc();
        send(mk(32'h701, 5'd0, 5'd0, 5'd0, 1'b0, SFU_ALU));
        cyc();
        dec_valid = 1'b0;
        RST       = 1'b1;
        cyc();
        RST = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_iss_valid", 32'(iss_valid), 0);
        chk("midrst_dec_ready", 32'(dec_ready), 1);
        fu_ready = 4'hF;
        send(mk(32'h710, 5'd1, 5'd2, 5'd0, 1'b0, SFU_ALU));
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("midrst_busy_cleared", 32'(iss_valid), 1);
        cyc();
        chk("midrst_done_count", 32'(count), 0);

        cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
